// File: rtl/ddr_to_sdr.sv
// Double-data-rate to single-data-rate input converter: both clk edges sampled, pair presented on rising edge.
// Latency 1 cycle (rise lane) / half cycle (fall lane); no backpressure. Optional sdr_valid via DDR_TO_SDR_VALID_EN.
module ddr_to_sdr #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ddr_data,
    output logic [DATA_W-1:0] sdr_data_0,
    output logic [DATA_W-1:0] sdr_data_1
`ifdef DDR_TO_SDR_VALID_EN
    ,
    output logic              sdr_valid
`endif
);

    logic [DATA_W-1:0] rise_q;
    logic [DATA_W-1:0] fall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise_q     <= '0;
            sdr_data_0 <= '0;
            sdr_data_1 <= '0;
        end else begin
            rise_q     <= ddr_data;
            sdr_data_0 <= rise_q;
            sdr_data_1 <= fall_q;
        end
    end

    // Falling-edge capture; retimed into the rising domain by sdr_data_1 above.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            fall_q <= '0;
        end else begin
            fall_q <= ddr_data;
        end
    end

`ifdef DDR_TO_SDR_VALID_EN
    logic rise_ok;
    logic fall_ok;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            fall_ok <= 1'b0;
        end else begin
            fall_ok <= 1'b1;
        end
    end

    // Sticky once both capture registers have held a post-reset sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise_ok   <= 1'b0;
            sdr_valid <= 1'b0;
        end else begin
            rise_ok   <= 1'b1;
            sdr_valid <= sdr_valid | (rise_ok & fall_ok);
        end
    end
`endif

endmodule

// File: tb/tb_ddr_to_sdr.sv
// Directed bench for ddr_to_sdr: reset hold, first pair, streaming, async mid-stream reset, constant data.
module tb_ddr_to_sdr;

    logic       clk;
    logic       rst;
    logic [7:0] ddr_data;
    logic [7:0] sdr_data_0;
    logic [7:0] sdr_data_1;
`ifdef DDR_TO_SDR_VALID_EN
    logic       sdr_valid;
`endif

    int vectors;
    int miscompares;

    ddr_to_sdr #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ddr_data   (ddr_data),
        .sdr_data_0 (sdr_data_0),
        .sdr_data_1 (sdr_data_1)
`ifdef DDR_TO_SDR_VALID_EN
        ,
        .sdr_valid  (sdr_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] e0, input logic [7:0] e1, input logic ev);
        vectors++;
        assert (sdr_data_0 === e0) else begin
            miscompares++;
            $error("FAIL %s sdr_data_0 observed=%h expected=%h", tag, sdr_data_0, e0);
        end
        vectors++;
        assert (sdr_data_1 === e1) else begin
            miscompares++;
            $error("FAIL %s sdr_data_1 observed=%h expected=%h", tag, sdr_data_1, e1);
        end
`ifdef DDR_TO_SDR_VALID_EN
        vectors++;
        assert (sdr_valid === ev) else begin
            miscompares++;
            $error("FAIL %s sdr_valid observed=%b expected=%b", tag, sdr_valid, ev);
        end
`else
        if (ev === 1'bx) $display("note: %s unexpected x valid", tag);
`endif
    endtask

    // r is stable around the next rising edge, f around the falling edge after it.
    task automatic drive_pair(input logic [7:0] r, input logic [7:0] f);
        @(negedge clk);
        #1 ddr_data = r;
        @(posedge clk);
        #1 ddr_data = f;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ddr_data    = 8'hFF;
        rst         = 1'b1;
        #1 rst      = 1'b0;

        // 1: held in reset while data toggles on both edges
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 check("rst_hold_rise", 8'h00, 8'h00, 1'b0);
            ddr_data = 8'h00;
            @(negedge clk);
            #1 check("rst_hold_fall", 8'h00, 8'h00, 1'b0);
            ddr_data = 8'hFF;
        end

        // 2: release just after a falling edge, first pair on the second rising edge
        @(negedge clk);
        #1 rst = 1'b1;
        ddr_data = 8'hAA;
        @(posedge clk);
        #1 check("first_edge", 8'h00, 8'h00, 1'b0);
        ddr_data = 8'h55;
        @(posedge clk);
        #1 check("first_pair", 8'hAA, 8'h55, 1'b1);

        // 3: back-to-back stream, each pair lands one cycle after its rising sample
        drive_pair(8'h01, 8'h02);
        drive_pair(8'h03, 8'h04);
        check("stream_0", 8'h01, 8'h02, 1'b1);
        drive_pair(8'hFF, 8'h00);
        check("stream_1", 8'h03, 8'h04, 1'b1);
        drive_pair(8'h00, 8'hFF);
        check("stream_2", 8'hFF, 8'h00, 1'b1);
        @(posedge clk);
        #1 check("stream_3", 8'h00, 8'hFF, 1'b1);
        @(negedge clk);
        #1 check("stream_3_fall", 8'h00, 8'hFF, 1'b1);

        // 4: async reset in the high phase with samples in flight
        drive_pair(8'h12, 8'h34);
        drive_pair(8'h56, 8'h78);
        check("pre_reset", 8'h12, 8'h34, 1'b1);
        #2 rst = 1'b0;
        #1 check("async_reset", 8'h00, 8'h00, 1'b0);
        ddr_data = 8'hE7;
        @(negedge clk);
        #1 check("reset_fall", 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1 check("reset_rise", 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        ddr_data = 8'h9C;
        @(posedge clk);
        #1 check("post_reset_edge", 8'h00, 8'h00, 1'b0);
        ddr_data = 8'hC9;
        @(posedge clk);
        #1 check("post_reset_pair", 8'h9C, 8'hC9, 1'b1);

        // 5: constant input, lanes stable across both edges
        @(negedge clk);
        #1 ddr_data = 8'h5A;
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            #1 check("const_rise", 8'h5A, 8'h5A, 1'b1);
            @(negedge clk);
            #1 check("const_fall", 8'h5A, 8'h5A, 1'b1);
            @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr_to_sdr.md
Name: ddr_to_sdr

Overview:
- Converts an 8-bit double-data-rate input bus into two single-data-rate 8-bit lanes.
- The bus is sampled on both clock edges and the two samples are presented together on the rising-edge domain.
- Sits at a source-synchronous input boundary, feeding rising-edge-only logic downstream.
- One clock; no handshake; a new pair is produced every cycle.

Parameters:
- DATA_W, 8, width of ddr_data and of each SDR output lane.

Ports:
- clk  input  1  DDR clock; data is valid around both the rising and the falling edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- ddr_data  input  DATA_W  DDR input bus.
- sdr_data_0  output  DATA_W  sample taken at the rising edge, registered.
- sdr_data_1  output  DATA_W  sample taken at the following falling edge, registered.

Behaviour:
- Internal registers:
  - rise_q: captures ddr_data on every posedge clk.
  - fall_q: captures ddr_data on every negedge clk.
- Output registers, on every posedge clk: sdr_data_0 <= rise_q and sdr_data_1 <= fall_q.
- Pairing: at rising edge N, rise_q takes sample R(N). At the next falling edge, fall_q takes sample F(N). At rising edge N+1, the outputs become {sdr_data_0 = R(N), sdr_data_1 = F(N)}.
- Latency:
  - Rise sample: 1 clk cycle.
  - Fall sample: half a clk cycle.
  - Both lanes always update on the same rising edge and never change on a falling edge.
- Reset:
  - rst low immediately (asynchronously) clears rise_q, fall_q, sdr_data_0 and sdr_data_1 to 0, regardless of clock.
  - This includes the negedge flops.
  - While rst is low, all outputs hold 0.
- Reset release: registers resume capture on their next respective edge.
  - The first valid pair appears on the second rising edge after release, if release precedes a rising edge.
  - Until then, the outputs show 0 or a partially-zero pair.
- Reset mid-stream: any in-flight samples are discarded; no stale data is emitted after release.
- No arithmetic or width conversion: bits pass through unchanged. Lane bit i equals ddr_data bit i.
- The input must meet setup and hold to both edges. Behaviour is undefined if ddr_data changes coincident with a clock edge.

Optional Feature:
- Macro: DDR_TO_SDR_VALID_EN.
- When defined, adds output port sdr_valid (1 bit).
  - Cleared asynchronously to 0 by reset.
  - Set to 1 on the first rising edge at which both rise_q and fall_q hold post-reset samples, i.e. the edge on which the first complete pair is loaded to the outputs.
  - Stays 1 until the next reset.
- When not defined: no sdr_valid port and no extra logic; the port list is exactly the one above.

Test Plan:
1. Hold rst=0 for 2 cycles with ddr_data=8'hFF toggling edges.
   - Outputs remain 8'h00.
   - With the macro, sdr_valid stays 0.
2. Release reset. Drive ddr_data=8'hAA stable around a rising edge, then 8'h55 around the following falling edge.
   - Next rising edge: sdr_data_0=8'hAA, sdr_data_1=8'h55.
3. Stream 4 pairs: (8'h01,8'h02), (8'h03,8'h04), (8'hFF,8'h00), (8'h00,8'hFF).
   - Each pair appears on consecutive rising edges, in order, with 1-cycle latency.
   - No lane swap occurs.
4. Assert rst mid-stream between edges.
   - Outputs go to 8'h00 immediately, without waiting for a clock edge.
   - After release, the first output pair reflects only post-reset samples.
5. Hold ddr_data constant at 8'h5A for many cycles.
   - Both lanes equal 8'h5A and are stable.
   - Neither lane changes on a falling edge.
6. With DDR_TO_SDR_VALID_EN defined: sdr_valid rises on the same rising edge as the first post-reset pair (scenario 2) and returns to 0 only on reset.
